regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Writeback stage directly upstream of the register file's write port. It collects results from two producers, the ALU and the load/store unit (LSU). Each producer has its own small FIFO. The block round-robin arbitrates between the FIFOs and drives one registered write per cycle into the register file using valid/ready. It drops writes to x0, preserves per-source order, and exposes a busy flag so issue logic can drain before a flush.

Parameters:
- ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: register data width.
- FIFO_DEPTH, 2: entries per source FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid_in  in  1  ALU result valid
- alu_ready_out  out  1  ALU FIFO can accept
- alu_rd_addr_in  in  ADDR_WIDTH  ALU destination register
- alu_data_in  in  DATA_WIDTH  ALU result
- lsu_valid_in  in  1  LSU result valid
- lsu_ready_out  out  1  LSU FIFO can accept
- lsu_rd_addr_in  in  ADDR_WIDTH  LSU destination register
- lsu_data_in  in  DATA_WIDTH  load data
- wr_addr_out  out  ADDR_WIDTH  to register file write address
- wr_data_out  out  DATA_WIDTH  to register file write data
- wr_data_valid_out  out  1  write request
- wr_data_ready_in  in  1  register file accepts write
- busy_out  out  1  any entry pending (FIFOs or output register)

Behaviour:
- Reset (rst high at posedge):
  - FIFOs emptied.
  - wr_data_valid_out=0, wr_addr_out=0, wr_data_out=0.
  - last_grant=LSU, so the ALU wins the first tie.
  - While rst is high, alu_ready_out=lsu_ready_out=0.
  - rst overrides every other action in the same cycle.
- Input handshake:
  - x_ready_out = !rst && FIFO_x not full. It does not depend on x_valid_in (no combinational loop).
  - A fire is x_valid_in && x_ready_out.
  - A fire with rd_addr==0 is accepted and discarded: no enqueue, no write issued.
- Output register:
  - It is "free" when !wr_data_valid_out, or when wr_data_valid_out && wr_data_ready_in in the current cycle.
  - When free and at least one FIFO is non-empty at the posedge, it loads the granted head, pops that FIFO, and sets valid=1.
  - When free and both FIFOs are empty, valid clears to 0.
  - When not free, addr, data and valid stay stable.
- Arbitration:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: grant the source not equal to last_grant.
  - last_grant updates only on a grant.
- Latency and throughput:
  - An input fire at the posedge ending cycle N produces wr_data_valid_out=1 in cycle N+2.
  - Sustained throughput is 1 write/cycle while wr_data_ready_in=1.
- Ordering:
  - FIFO order is preserved within each source.
  - No ordering is guaranteed across sources. Issue logic must not have ALU and LSU writes to the same rd in flight simultaneously.
- FIFO boundaries:
  - Simultaneous push and pop on a full FIFO is not allowed: ready_out is already 0 when the FIFO is full.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Capacity per source: FIFO_DEPTH entries in the FIFO plus at most one in the output register.
- busy_out = FIFO_alu non-empty || FIFO_lsu non-empty || wr_data_valid_out. It is combinational from state only.
- Mid-operation reset: all pending writes are lost. No partial write is presented after the rst cycle.

Decomposition:
- Package wb_pkg contains:
  - typedef wb_src_e {WB_SRC_ALU, WB_SRC_LSU}
  - struct wb_entry_t {addr, data}, with widths from the package constants WB_ADDR_WIDTH=5 and WB_DATA_WIDTH=32
  - constant REG_ZERO=0
- One sub-module: wb_fifo.
  - Parameterised synchronous FIFO of wb_entry_t.
  - Ports: push, pop, full, empty, head.
  - Instantiated twice.

Test Plan:
1. Reset: hold rst 2 cycles with alu_valid_in=1, rd=3 -> alu_ready_out=0 and wr_data_valid_out=0 throughout; no write appears after release until a new fire.
2. Single write: ALU fire rd=5, data=0xDEADBEEF at cycle 0, ready_in=1 -> cycle 2 has valid=1, addr=5, data=0xDEADBEEF; cycle 3 has valid=0 and busy_out=0.
3. x0 drop: ALU fire rd=0, data=0x1234 -> alu_ready_out=1 at the fire; no write ever issued; busy_out stays 0.
4. Tie: after reset, ALU (rd=1, 0x11) and LSU (rd=2, 0x22) fire in the same cycle -> rd=1 write in cycle 2, rd=2 write in cycle 3. A repeat tie grants LSU first.
5. Backpressure: ready_in=0, ALU pushes rd=1..4 -> rd=1..3 accepted; alu_ready_out=0 from the 4th attempt; outputs held at rd=1. Release ready_in -> rd=1, 2, 3, 4 on consecutive cycles.
6. Mid-operation reset: 3 entries pending, assert rst 1 cycle -> next cycle valid=0 and busy_out=0; none of the pending addresses is ever written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: source tags, the queued
// write entry, and the x0 address that is never written.
package wb_pkg;

   localparam int WB_ADDR_WIDTH = 5;
   localparam int WB_DATA_WIDTH = 32;

   localparam logic [WB_ADDR_WIDTH-1:0] REG_ZERO = '0;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0] addr;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_entry_t;

   function automatic wb_src_e wb_other_src(input wb_src_e src);
      return (src == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries. A push into a full FIFO or a pop
// from an empty one is ignored.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   wb_entry_t        r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign full   = (r_count == (PTR_W+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign head   = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: queues ALU and LSU results in per-source FIFOs and issues
// one registered register-file write per cycle, round-robin between sources.
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid_in,
   output logic                  alu_ready_out,
   input  logic [ADDR_WIDTH-1:0] alu_rd_addr_in,
   input  logic [DATA_WIDTH-1:0] alu_data_in,
   input  logic                  lsu_valid_in,
   output logic                  lsu_ready_out,
   input  logic [ADDR_WIDTH-1:0] lsu_rd_addr_in,
   input  logic [DATA_WIDTH-1:0] lsu_data_in,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output logic [DATA_WIDTH-1:0] wr_data_out,
   output logic                  wr_data_valid_out,
   input  logic                  wr_data_ready_in,
   output logic                  busy_out
);

   logic                  r_wr_valid;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   wb_src_e               r_last_grant;

   wb_entry_t w_alu_entry;
   wb_entry_t w_lsu_entry;
   wb_entry_t w_alu_head;
   wb_entry_t w_lsu_head;
   wb_entry_t w_grant_entry;
   wb_src_e   w_grant_src;
   logic      w_alu_full;
   logic      w_alu_empty;
   logic      w_lsu_full;
   logic      w_lsu_empty;
   logic      w_alu_push;
   logic      w_lsu_push;
   logic      w_alu_pop;
   logic      w_lsu_pop;
   logic      w_out_free;
   logic      w_grant_vld;

   // Ready never looks at valid, so upstream can't form a combinational loop.
   assign alu_ready_out = !rst && !w_alu_full;
   assign lsu_ready_out = !rst && !w_lsu_full;

   // Writes to x0 complete the handshake but are never queued.
   assign w_alu_push = alu_valid_in && alu_ready_out && (alu_rd_addr_in != REG_ZERO);
   assign w_lsu_push = lsu_valid_in && lsu_ready_out && (lsu_rd_addr_in != REG_ZERO);

   assign w_alu_entry = '{addr: alu_rd_addr_in, data: alu_data_in};
   assign w_lsu_entry = '{addr: lsu_rd_addr_in, data: lsu_data_in};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_alu_push),
      .push_data (w_alu_entry),
      .pop       (w_alu_pop),
      .full      (w_alu_full),
      .empty     (w_alu_empty),
      .head      (w_alu_head)
   );

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_lsu_push),
      .push_data (w_lsu_entry),
      .pop       (w_lsu_pop),
      .full      (w_lsu_full),
      .empty     (w_lsu_empty),
      .head      (w_lsu_head)
   );

   // On a tie the source that did not win last time is granted.
   always_comb begin
      w_grant_src = WB_SRC_ALU;
      if (!w_alu_empty && !w_lsu_empty) begin
         w_grant_src = wb_other_src(r_last_grant);
      end else if (w_alu_empty) begin
         w_grant_src = WB_SRC_LSU;
      end
   end

   assign w_out_free    = !r_wr_valid || wr_data_ready_in;
   assign w_grant_vld   = w_out_free && !(w_alu_empty && w_lsu_empty);
   assign w_alu_pop     = w_grant_vld && (w_grant_src == WB_SRC_ALU);
   assign w_lsu_pop     = w_grant_vld && (w_grant_src == WB_SRC_LSU);
   assign w_grant_entry = (w_grant_src == WB_SRC_ALU) ? w_alu_head : w_lsu_head;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_valid   <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_last_grant <= WB_SRC_LSU;
      end else if (w_out_free) begin
         if (w_grant_vld) begin
            r_wr_valid   <= 1'b1;
            r_wr_addr    <= w_grant_entry.addr;
            r_wr_data    <= w_grant_entry.data;
            r_last_grant <= w_grant_src;
         end else begin
            r_wr_valid <= 1'b0;
         end
      end
   end

   assign wr_addr_out       = r_wr_addr;
   assign wr_data_out       = r_wr_data;
   assign wr_data_valid_out = r_wr_valid;
   assign busy_out          = !w_alu_empty || !w_lsu_empty || r_wr_valid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue that a
// negedge monitor drains whenever the register file accepts a write.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid_in;
   logic        alu_ready_out;
   logic [4:0]  alu_rd_addr_in;
   logic [31:0] alu_data_in;
   logic        lsu_valid_in;
   logic        lsu_ready_out;
   logic [4:0]  lsu_rd_addr_in;
   logic [31:0] lsu_data_in;
   logic [4:0]  wr_addr_out;
   logic [31:0] wr_data_out;
   logic        wr_data_valid_out;
   logic        wr_data_ready_in;
   logic        busy_out;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .alu_valid_in      (alu_valid_in),
      .alu_ready_out     (alu_ready_out),
      .alu_rd_addr_in    (alu_rd_addr_in),
      .alu_data_in       (alu_data_in),
      .lsu_valid_in      (lsu_valid_in),
      .lsu_ready_out     (lsu_ready_out),
      .lsu_rd_addr_in    (lsu_rd_addr_in),
      .lsu_data_in       (lsu_data_in),
      .wr_addr_out       (wr_addr_out),
      .wr_data_out       (wr_data_out),
      .wr_data_valid_out (wr_data_valid_out),
      .wr_data_ready_in  (wr_data_ready_in),
      .busy_out          (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every accepted write must match the next expected one.
   always @(negedge clk) begin
      if (!rst && wr_data_valid_out && wr_data_ready_in) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                     wr_addr_out, wr_data_out);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_addr", 64'(wr_addr_out), 64'(mon_e.a));
            chk("sb_data", 64'(wr_data_out), 64'(mon_e.d));
         end
      end
   end

   initial begin
      rst              = 1'b1;
      alu_valid_in     = 1'b1;
      alu_rd_addr_in   = 5'd3;
      alu_data_in      = 32'h3333_3333;
      lsu_valid_in     = 1'b0;
      lsu_rd_addr_in   = 5'd0;
      lsu_data_in      = 32'h0;
      wr_data_ready_in = 1'b1;

      // 1. Reset held two cycles with an ALU request pending.
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_alu_ready", 64'(alu_ready_out), 64'd0);
         chk("rst_lsu_ready", 64'(lsu_ready_out), 64'd0);
         chk("rst_valid", 64'(wr_data_valid_out), 64'd0);
         chk("rst_addr", 64'(wr_addr_out), 64'd0);
         chk("rst_data", 64'(wr_data_out), 64'd0);
         chk("rst_busy", 64'(busy_out), 64'd0);
      end
      rst          = 1'b0;
      alu_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_valid", 64'(wr_data_valid_out), 64'd0);
         chk("post_rst_busy", 64'(busy_out), 64'd0);
      end

      // 2. Single ALU write, two-cycle latency.
      alu_valid_in   = 1'b1;
      alu_rd_addr_in = 5'd5;
      alu_data_in    = 32'hDEAD_BEEF;
      chk("single_ready", 64'(alu_ready_out), 64'd1);
      expect_wr(5'd5, 32'hDEAD_BEEF);
      step();
      alu_valid_in = 1'b0;
      chk("single_c1_valid", 64'(wr_data_valid_out), 64'd0);
      chk("single_c1_busy", 64'(busy_out), 64'd1);
      step();
      chk("single_c2_valid", 64'(wr_data_valid_out), 64'd1);
      chk("single_c2_addr", 64'(wr_addr_out), 64'd5);
      chk("single_c2_data", 64'(wr_data_out), 64'hDEAD_BEEF);
      step();
      chk("single_c3_valid", 64'(wr_data_valid_out), 64'd0);
      chk("single_c3_busy", 64'(busy_out), 64'd0);

      // 3. Write to x0 is accepted and dropped.
      alu_valid_in   = 1'b1;
      alu_rd_addr_in = 5'd0;
      alu_data_in    = 32'h1234;
      chk("x0_ready", 64'(alu_ready_out), 64'd1);
      step();
      alu_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("x0_valid", 64'(wr_data_valid_out), 64'd0);
         chk("x0_busy", 64'(busy_out), 64'd0);
         step();
      end

      // 4. Tie after reset: ALU first; after an ALU-only write, LSU wins the tie.
      rst = 1'b1;
      step();
      rst            = 1'b0;
      alu_valid_in   = 1'b1;
      alu_rd_addr_in = 5'd1;
      alu_data_in    = 32'h11;
      lsu_valid_in   = 1'b1;
      lsu_rd_addr_in = 5'd2;
      lsu_data_in    = 32'h22;
      expect_wr(5'd1, 32'h11);
      expect_wr(5'd2, 32'h22);
      step();
      alu_valid_in = 1'b0;
      lsu_valid_in = 1'b0;
      step();
      chk("tie1_c2_addr", 64'(wr_addr_out), 64'd1);
      step();
      chk("tie1_c3_valid", 64'(wr_data_valid_out), 64'd1);
      chk("tie1_c3_addr", 64'(wr_addr_out), 64'd2);
      step();
      chk("tie1_c4_valid", 64'(wr_data_valid_out), 64'd0);

      alu_valid_in   = 1'b1;
      alu_rd_addr_in = 5'd7;
      alu_data_in    = 32'h77;
      expect_wr(5'd7, 32'h77);
      step();
      alu_valid_in = 1'b0;
      step();
      step();
      alu_valid_in   = 1'b1;
      alu_rd_addr_in = 5'd8;
      alu_data_in    = 32'h88;
      lsu_valid_in   = 1'b1;
      lsu_rd_addr_in = 5'd9;
      lsu_data_in    = 32'h99;
      expect_wr(5'd9, 32'h99);
      expect_wr(5'd8, 32'h88);
      step();
      alu_valid_in = 1'b0;
      lsu_valid_in = 1'b0;
      step();
      chk("tie2_c2_addr", 64'(wr_addr_out), 64'd9);
      step();
      chk("tie2_c3_addr", 64'(wr_addr_out), 64'd8);
      step();
      chk("tie2_c4_valid", 64'(wr_data_valid_out), 64'd0);

      // 5. Backpressure: FIFO fills at rd=3, drains back-to-back on release.
      wr_data_ready_in = 1'b0;
      alu_valid_in     = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         alu_rd_addr_in = 5'(i);
         alu_data_in    = 32'h100 + 32'(i);
         chk("bp_accept_ready", 64'(alu_ready_out), 64'd1);
         expect_wr(5'(i), 32'h100 + 32'(i));
         step();
      end
      alu_rd_addr_in = 5'd4;
      alu_data_in    = 32'h104;
      expect_wr(5'd4, 32'h104);
      for (int i = 0; i < 3; i++) begin
         chk("bp_full_ready", 64'(alu_ready_out), 64'd0);
         chk("bp_hold_valid", 64'(wr_data_valid_out), 64'd1);
         chk("bp_hold_addr", 64'(wr_addr_out), 64'd1);
         chk("bp_hold_busy", 64'(busy_out), 64'd1);
         step();
      end
      wr_data_ready_in = 1'b1;
      chk("bp_r0_addr", 64'(wr_addr_out), 64'd1);
      step();
      chk("bp_r1_ready", 64'(alu_ready_out), 64'd1);
      chk("bp_r1_addr", 64'(wr_addr_out), 64'd2);
      step();
      alu_valid_in = 1'b0;
      chk("bp_r2_addr", 64'(wr_addr_out), 64'd3);
      step();
      chk("bp_r3_valid", 64'(wr_data_valid_out), 64'd1);
      chk("bp_r3_addr", 64'(wr_addr_out), 64'd4);
      step();
      chk("bp_r4_valid", 64'(wr_data_valid_out), 64'd0);

      // 6. Reset with three writes pending: none may ever reach the register file.
      wr_data_ready_in = 1'b0;
      alu_valid_in     = 1'b1;
      alu_rd_addr_in   = 5'd10;
      alu_data_in      = 32'hA0;
      lsu_valid_in     = 1'b1;
      lsu_rd_addr_in   = 5'd12;
      lsu_data_in      = 32'hC0;
      step();
      lsu_valid_in   = 1'b0;
      alu_rd_addr_in = 5'd11;
      alu_data_in    = 32'hB0;
      step();
      alu_valid_in = 1'b0;
      chk("mid_pending_busy", 64'(busy_out), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 64'(wr_data_valid_out), 64'd0);
      chk("mid_rst_busy", 64'(busy_out), 64'd0);
      wr_data_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_after_valid", 64'(wr_data_valid_out), 64'd0);
      end

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
